// File: rtl/eth_tx_payload_buffer.sv
// Whole-packet payload buffer ahead of the 10G UDP/ARP transmitter.
// Define ETH_TX_BUF_STATS_EN to add saturating sent/dropped packet counters.
module eth_tx_payload_buffer #(
  parameter int ADDR_W    = 9,
  parameter int LEN_AW    = 2,
  parameter int MAX_BYTES = 1472
) (
  input  logic        clk_156_25,
  input  logic        rst,
  input  logic [63:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  input  logic [2:0]  s_empty,
  output logic        s_ready,
  output logic        tx_start,
  input  logic        tx_idle,
  output logic [15:0] data_length,
  input  logic        rd_req,
  output logic [63:0] rd_data,
  output logic        pkt_drop
`ifdef ETH_TX_BUF_STATS_EN
  ,
  output logic [31:0] stat_tx_pkts,
  output logic [15:0] stat_drops
`endif
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LDEPTH = 1 << LEN_AW;

  typedef logic [ADDR_W:0] ptr_t;
  typedef logic [LEN_AW:0] lptr_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BUSY,
    SEND,
    DONE
  } state_t;

  logic [63:0] mem_q [DEPTH];
  logic [15:0] len_mem_q [LDEPTH];

  ptr_t        wptr_q, wptr_d;
  ptr_t        wcmt_q, wcmt_d;
  ptr_t        rptr_q, rptr_d;
  lptr_t       lwp_q, lwp_d;
  lptr_t       lrp_q, lrp_d;
  logic [15:0] cnt_q, cnt_d;
  logic        drop_q, drop_d;
  logic        pkt_drop_q, pkt_drop_d;
  state_t      state_q, state_d;
  logic [15:0] dlen_q, dlen_d;
  logic [13:0] wl_q, wl_d;
  logic [63:0] rd_q, rd_d;

  ptr_t        used;
  logic        len_full;
  logic        len_empty;
  logic        acc;
  logic [15:0] beat_bytes;
  logic [15:0] cnt_nxt;
  logic        over;
  logic        mem_we;
  logic        push;
  logic        pop;
  logic [15:0] len_head;
  logic [16:0] len_sum;

  assign used      = wptr_q - rptr_q;
  assign len_empty = (lwp_q == lrp_q);
  assign len_full  = (lwp_q[LEN_AW] != lrp_q[LEN_AW]) &&
                     (lwp_q[LEN_AW-1:0] == lrp_q[LEN_AW-1:0]);

  // A packet being discarded is sunk regardless of buffer space.
  assign s_ready = ~rst & (drop_q | (~used[ADDR_W] & ~len_full));
  assign acc     = s_valid & s_ready;

  assign beat_bytes = 16'd8 - (s_last ? {13'd0, s_empty} : 16'd0);
  assign cnt_nxt    = cnt_q + beat_bytes;
  assign over       = cnt_nxt > 16'(MAX_BYTES);
  assign mem_we     = acc & ~drop_q & ~over;
  assign push       = mem_we & s_last;

  assign len_head = len_mem_q[lrp_q[LEN_AW-1:0]];
  assign len_sum  = {1'b0, len_head} + 17'd7;

  assign tx_start    = (state_q == START);
  assign data_length = dlen_q;
  assign rd_data     = rd_q;
  assign pkt_drop    = pkt_drop_q;

  always_comb begin
    wptr_d     = wptr_q;
    wcmt_d     = wcmt_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q;
    pkt_drop_d = 1'b0;
    if (acc) begin
      if (s_last) begin
        cnt_d  = '0;
        drop_d = 1'b0;
        if (drop_q | over) begin
          wptr_d     = wcmt_q;
          pkt_drop_d = 1'b1;
        end else begin
          wptr_d = wptr_q + ptr_t'(1);
          wcmt_d = wptr_q + ptr_t'(1);
        end
      end else if (drop_q | over) begin
        drop_d = 1'b1;
      end else begin
        wptr_d = wptr_q + ptr_t'(1);
        cnt_d  = cnt_nxt;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dlen_d  = dlen_q;
    wl_d    = wl_q;
    rptr_d  = rptr_q;
    rd_d    = rd_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!len_empty && tx_idle) begin
          dlen_d  = len_head;
          wl_d    = len_sum[16:3];
          state_d = START;
        end
      end
      START: state_d = BUSY;
      BUSY: begin
        if (!tx_idle) state_d = SEND;
      end
      SEND: begin
        if (rd_req && wl_q != '0) begin
          rd_d   = mem_q[rptr_q[ADDR_W-1:0]];
          rptr_d = rptr_q + ptr_t'(1);
          wl_d   = wl_q - 14'd1;
          if (wl_q == 14'd1) begin
            pop     = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (tx_idle) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign lwp_d = lwp_q + lptr_t'(push);
  assign lrp_d = lrp_q + lptr_t'(pop);

  always_ff @(posedge clk_156_25) begin
    if (mem_we) mem_q[wptr_q[ADDR_W-1:0]] <= s_data;
    if (push) len_mem_q[lwp_q[LEN_AW-1:0]] <= cnt_nxt;
  end

  always_ff @(posedge clk_156_25) begin
    if (rst) begin
      wptr_q     <= '0;
      wcmt_q     <= '0;
      rptr_q     <= '0;
      lwp_q      <= '0;
      lrp_q      <= '0;
      cnt_q      <= '0;
      drop_q     <= 1'b0;
      pkt_drop_q <= 1'b0;
      state_q    <= IDLE;
      dlen_q     <= '0;
      wl_q       <= '0;
      rd_q       <= '0;
    end else begin
      wptr_q     <= wptr_d;
      wcmt_q     <= wcmt_d;
      rptr_q     <= rptr_d;
      lwp_q      <= lwp_d;
      lrp_q      <= lrp_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      pkt_drop_q <= pkt_drop_d;
      state_q    <= state_d;
      dlen_q     <= dlen_d;
      wl_q       <= wl_d;
      rd_q       <= rd_d;
    end
  end

`ifdef ETH_TX_BUF_STATS_EN
  logic [31:0] stp_q, stp_d;
  logic [15:0] sdr_q, sdr_d;

  always_comb begin
    stp_d = stp_q;
    sdr_d = sdr_q;
    if (pop && stp_q != '1) stp_d = stp_q + 32'd1;
    if (pkt_drop_q && sdr_q != '1) sdr_d = sdr_q + 16'd1;
  end

  always_ff @(posedge clk_156_25) begin
    if (rst) begin
      stp_q <= '0;
      sdr_q <= '0;
    end else begin
      stp_q <= stp_d;
      sdr_q <= sdr_d;
    end
  end

  assign stat_tx_pkts = stp_q;
  assign stat_drops   = sdr_q;
`endif

endmodule

// File: tb/tb_eth_tx_payload_buffer.sv
// Directed bench for eth_tx_payload_buffer.
// Models the transmitter handshake and checks data_length and fetched words.
`timescale 1ns/1ps
module tb_eth_tx_payload_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic [2:0]  s_empty;
  logic        s_ready;
  logic        tx_start;
  logic        tx_idle;
  logic [15:0] data_length;
  logic        rd_req;
  logic [63:0] rd_data;
  logic        pkt_drop;
`ifdef ETH_TX_BUF_STATS_EN
  logic [31:0] stat_tx_pkts;
  logic [15:0] stat_drops;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_starts = 0;
  int n_drops = 0;
  logic [63:0] exp_q [$];

  always #3.2 clk = ~clk;

  eth_tx_payload_buffer dut (
    .clk_156_25 (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_empty    (s_empty),
    .s_ready    (s_ready),
    .tx_start   (tx_start),
    .tx_idle    (tx_idle),
    .data_length(data_length),
    .rd_req     (rd_req),
    .rd_data    (rd_data),
    .pkt_drop   (pkt_drop)
`ifdef ETH_TX_BUF_STATS_EN
    ,
    .stat_tx_pkts(stat_tx_pkts),
    .stat_drops  (stat_drops)
`endif
  );

  always @(negedge clk) begin
    if (tx_start === 1'b1) n_starts <= n_starts + 1;
    if (pkt_drop === 1'b1) n_drops <= n_drops + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [63:0] d, input bit last,
                           input logic [2:0] e);
    int t;
    t = 0;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    s_empty = e;
    while (s_ready !== 1'b1 && t < 200) begin
      tick();
      t++;
    end
    if (s_ready !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout s_ready=%b required 1", s_ready);
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_empty = 3'd0;
  endtask

  task automatic push_pkt(input int nbeats, input logic [2:0] e,
                          input bit keep, input logic [63:0] base);
    for (int i = 0; i < nbeats; i++) begin
      push_beat(base + 64'(i), (i == nbeats - 1), e);
      if (keep) exp_q.push_back(base + 64'(i));
    end
  endtask

  task automatic serve_pkt(input logic [15:0] exp_len, input string nm);
    int t;
    int nw;
    logic [63:0] ew;
    logic [63:0] held;
    t = 0;
    while (tx_start !== 1'b1 && t < 100) begin
      tick();
      t++;
    end
    n_cmp++;
    if (tx_start !== 1'b1) begin
      n_err++;
      $display("FAIL %s_start got tx_start=%b required 1", nm, tx_start);
      return;
    end
    n_cmp++;
    if (data_length !== exp_len) begin
      n_err++;
      $display("FAIL %s_len got %0d required %0d", nm, data_length, exp_len);
    end
    tx_idle = 1'b0;
    tick();
    tick();
    nw = (int'(exp_len) + 7) / 8;
    for (int i = 0; i < nw; i++) begin
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      ew = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
      n_cmp++;
      if (rd_data !== ew) begin
        n_err++;
        $display("FAIL %s_word%0d got %h required %h", nm, i, rd_data, ew);
      end
    end
    held = rd_data;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    n_cmp++;
    if (rd_data !== held) begin
      n_err++;
      $display("FAIL %s_extra_req got %h required %h", nm, rd_data, held);
    end
    n_cmp++;
    if (data_length !== exp_len) begin
      n_err++;
      $display("FAIL %s_len_hold got %0d required %0d", nm, data_length, exp_len);
    end
    tx_idle = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_s_ready got %b required 0", s_ready);
    end
    n_cmp++;
    if (tx_start !== 1'b0) begin
      n_err++;
      $display("FAIL rst_tx_start got %b required 0", tx_start);
    end
    n_cmp++;
    if (data_length !== 16'd0) begin
      n_err++;
      $display("FAIL rst_len got %0d required 0", data_length);
    end
    n_cmp++;
    if (rd_data !== 64'd0) begin
      n_err++;
      $display("FAIL rst_rd_data got %h required 0", rd_data);
    end
    n_cmp++;
    if (pkt_drop !== 1'b0) begin
      n_err++;
      $display("FAIL rst_pkt_drop got %b required 0", pkt_drop);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL post_rst_s_ready got %b required 1", s_ready);
    end
  endtask

  task automatic test_three_beat();
    push_pkt(3, 3'd2, 1'b1, 64'hA0A1A2A3_00000010);
    serve_pkt(16'd22, "three_beat");
  endtask

  task automatic test_single_beat();
    push_pkt(1, 3'd0, 1'b1, 64'h01020304_05060708);
    serve_pkt(16'd8, "single_beat");
  endtask

  task automatic test_oversize();
    int d0;
    int s0;
    d0 = n_drops;
    s0 = n_starts;
    push_pkt(190, 3'd0, 1'b0, 64'hBAD0_0000_0000_0000);
    n_cmp++;
    if (pkt_drop !== 1'b1) begin
      n_err++;
      $display("FAIL drop_pulse got %b required 1", pkt_drop);
    end
    repeat (10) tick();
    n_cmp++;
    if (n_drops !== d0 + 1) begin
      n_err++;
      $display("FAIL drop_count got %0d required %0d", n_drops - d0, 1);
    end
    n_cmp++;
    if (n_starts !== s0) begin
      n_err++;
      $display("FAIL drop_no_start got %0d starts required 0", n_starts - s0);
    end
    push_pkt(2, 3'd0, 1'b1, 64'hC0DE_0000_0000_0100);
    serve_pkt(16'd16, "after_drop");
  endtask

  task automatic test_queue_full();
    tx_idle = 1'b0;
    push_pkt(1, 3'd0, 1'b1, 64'h1111_0000_0000_0000);
    push_pkt(2, 3'd3, 1'b1, 64'h2222_0000_0000_0000);
    push_pkt(1, 3'd7, 1'b1, 64'h3333_0000_0000_0000);
    push_pkt(3, 3'd0, 1'b1, 64'h4444_0000_0000_0000);
    s_data  = 64'h5555_0000_0000_0000;
    s_valid = 1'b1;
    s_last  = 1'b0;
    tick();
    n_cmp++;
    if (s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_s_ready got %b required 0", s_ready);
    end
    s_valid = 1'b0;
    tick();
    tx_idle = 1'b1;
    serve_pkt(16'd8, "q0");
    serve_pkt(16'd13, "q1");
    serve_pkt(16'd1, "q2");
    serve_pkt(16'd24, "q3");
  endtask

  task automatic test_reset_mid_send();
    int t;
    int s0;
    push_pkt(5, 3'd0, 1'b1, 64'h7777_0000_0000_0000);
    t = 0;
    while (tx_start !== 1'b1 && t < 100) begin
      tick();
      t++;
    end
    n_cmp++;
    if (tx_start !== 1'b1) begin
      n_err++;
      $display("FAIL mid_start got %b required 1", tx_start);
    end
    tx_idle = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      n_cmp++;
      if (rd_data !== exp_q[0]) begin
        n_err++;
        $display("FAIL mid_word%0d got %h required %h", i, rd_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (tx_start !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst_start got %b required 0", tx_start);
    end
    n_cmp++;
    if (rd_data !== 64'd0) begin
      n_err++;
      $display("FAIL mid_rst_rd_data got %h required 0", rd_data);
    end
    n_cmp++;
    if (data_length !== 16'd0) begin
      n_err++;
      $display("FAIL mid_rst_len got %0d required 0", data_length);
    end
    rst = 1'b0;
    tx_idle = 1'b1;
    exp_q.delete();
    s0 = n_starts;
    repeat (12) tick();
    n_cmp++;
    if (n_starts !== s0) begin
      n_err++;
      $display("FAIL mid_rst_pending got %0d starts required 0", n_starts - s0);
    end
  endtask

`ifdef ETH_TX_BUF_STATS_EN
  task automatic test_stats();
    push_pkt(1, 3'd0, 1'b1, 64'h8888_0000_0000_0000);
    serve_pkt(16'd8, "stat0");
    push_pkt(2, 3'd1, 1'b1, 64'h9999_0000_0000_0000);
    serve_pkt(16'd15, "stat1");
    push_pkt(185, 3'd0, 1'b0, 64'hBAD1_0000_0000_0000);
    repeat (4) tick();
    n_cmp++;
    if (stat_tx_pkts !== 32'd2) begin
      n_err++;
      $display("FAIL stat_tx_pkts got %0d required 2", stat_tx_pkts);
    end
    n_cmp++;
    if (stat_drops !== 16'd1) begin
      n_err++;
      $display("FAIL stat_drops got %0d required 1", stat_drops);
    end
  endtask
`endif

  initial begin
    rst     = 1'b1;
    s_data  = '0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_empty = 3'd0;
    tx_idle = 1'b1;
    rd_req  = 1'b0;
    test_reset();
    test_three_beat();
    test_single_beat();
    test_oversize();
    test_queue_full();
    test_reset_mid_send();
`ifdef ETH_TX_BUF_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
